// File: rtl/aes_round_key_engine.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_key_engine
// Brief    : Sequential AES-128 round-key generator. Accepts a cipher key and
//            a target round over valid/ready, iterates one KeyGeneration step
//            per clock and returns the requested round key over valid/ready.
//            Optional macro ROUND_KEY_CACHE_EN adds a round-key cache so that
//            repeated requests for the same cipher key skip the expansion.
// Revision : 1.0 - initial release
// ============================================================================
module aes_round_key_engine #(
    parameter int MAX_ROUND = 10,
    parameter int RW        = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [127:0]  req_key_i,
    input  logic [RW-1:0] req_round_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [127:0]  rsp_key_o,
    output logic [RW-1:0] rsp_round_o,
    output logic          rsp_err_o,
    output logic          busy_o
);

    localparam logic [RW-1:0] c_max_round = RW'(MAX_ROUND);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // GF(2^8) multiply with the AES reduction polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        logic [7:0] bb;
        acc = 8'h00;
        aa  = a;
        bb  = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) acc = acc ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return acc;
    endfunction

    // S-box computed as affine(x^254); x^254 is the field inverse (0 maps to 0).
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] b;
        p = x;
        b = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            b = gf_mul(b, p);
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Round constant for the step producing round key rc+1.
    function automatic logic [7:0] rcon(input logic [3:0] rc);
        case (rc)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One AES-128 key-schedule step: round key rc -> round key rc+1.
    function automatic logic [127:0] key_generation(input logic [3:0] rc,
                                                    input logic [127:0] key);
        logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
        w0  = key[127:96];
        w1  = key[95:64];
        w2  = key[63:32];
        w3  = key[31:0];
        rot = {w3[23:0], w3[31:24]};
        t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
              ^ {rcon(rc), 24'h000000};
        n0  = w0 ^ t;
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_t          state_q;
    logic [127:0]    wk_q;
    logic [RW-1:0]   cnt_q;
    logic [RW-1:0]   round_q;
    logic            req_ready_q;
    logic            rsp_valid_q;
    logic [127:0]    rsp_key_q;
    logic [RW-1:0]   rsp_round_q;
    logic            rsp_err_q;
    logic            busy_q;

    logic [127:0]    wk_d;
    logic [3:0]      w_rc;
    logic [RW-1:0]   w_cnt_inc;
    logic            w_accept;
    logic            w_req_err;

    assign w_rc      = 4'(cnt_q);
    assign wk_d      = key_generation(w_rc, wk_q);
    assign w_cnt_inc = cnt_q + RW'(1);
    assign w_accept  = (state_q == S_IDLE) && req_ready_q && req_valid_i;
    assign w_req_err = (req_round_i > c_max_round);

`ifdef ROUND_KEY_CACHE_EN
    logic [127:0]    tag_q;
    logic [RW-1:0]   hw_q;
    logic            cvalid_q;
    logic [127:0]    mem_q [0:MAX_ROUND];

    logic            w_tag_hit;
    logic            w_beyond_hw;
    logic            w_mem_we;
    logic [RW-1:0]   w_mem_addr;
    logic [127:0]    w_mem_data;

    assign w_tag_hit   = cvalid_q && (tag_q == req_key_i);
    assign w_beyond_hw = (req_round_i > hw_q);

    // Cache write port: entry 0 on a retag, entry cnt+1 on every expansion step.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = '0;
        w_mem_data = wk_d;
        if (w_accept && !w_req_err && !w_tag_hit) begin
            w_mem_we   = 1'b1;
            w_mem_addr = '0;
            w_mem_data = req_key_i;
        end else if (state_q == S_EXPAND) begin
            w_mem_we   = 1'b1;
            w_mem_addr = w_cnt_inc;
            w_mem_data = wk_d;
        end
    end

    // Round-key storage; contents are qualified by cvalid_q so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_mem_we) mem_q[w_mem_addr] <= w_mem_data;
    end
`endif

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wk_q        <= '0;
            cnt_q       <= '0;
            round_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_key_q   <= '0;
            rsp_round_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ROUND_KEY_CACHE_EN
            tag_q       <= '0;
            hw_q        <= '0;
            cvalid_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (w_accept) begin
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        wk_q        <= req_key_i;
                        cnt_q       <= '0;
                        round_q     <= req_round_i;
                        if (w_req_err) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_key_q   <= '0;
                            rsp_round_q <= req_round_i;
                            rsp_err_q   <= 1'b1;
                        end
`ifdef ROUND_KEY_CACHE_EN
                        else if (w_tag_hit && !w_beyond_hw) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_key_q   <= mem_q[req_round_i];
                            rsp_round_q <= req_round_i;
                            rsp_err_q   <= 1'b0;
                        end else if (w_tag_hit) begin
                            // Resume from the highest round already stored.
                            wk_q    <= mem_q[hw_q];
                            cnt_q   <= hw_q;
                            state_q <= S_EXPAND;
                        end
`endif
                        else begin
`ifdef ROUND_KEY_CACHE_EN
                            tag_q    <= req_key_i;
                            hw_q     <= '0;
                            cvalid_q <= 1'b1;
`endif
                            if (req_round_i == '0) begin
                                state_q     <= S_RESP;
                                rsp_valid_q <= 1'b1;
                                rsp_key_q   <= req_key_i;
                                rsp_round_q <= req_round_i;
                                rsp_err_q   <= 1'b0;
                            end else begin
                                state_q <= S_EXPAND;
                            end
                        end
                    end
                end
                S_EXPAND: begin
                    wk_q  <= wk_d;
                    cnt_q <= w_cnt_inc;
`ifdef ROUND_KEY_CACHE_EN
                    hw_q  <= w_cnt_inc;
`endif
                    if (w_cnt_inc == round_q) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_key_q   <= wk_d;
                        rsp_round_q <= round_q;
                        rsp_err_q   <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_key_o   = rsp_key_q;
    assign rsp_round_o = rsp_round_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_key_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_round_key_engine
// Brief    : Scoreboard bench for aes_round_key_engine. The driver pushes the
//            expected key/round/err/latency on each accepted request; a
//            monitor pops and compares on each new response. Expected keys
//            are the FIPS-197 AES-128 key schedules of two reference keys.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_round_key_engine;

    localparam int MAX_ROUND = 10;
    localparam int RW        = 4;
`ifdef ROUND_KEY_CACHE_EN
    localparam bit CACHE_EN  = 1'b1;
`else
    localparam bit CACHE_EN  = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [127:0]  req_key_i;
    logic [RW-1:0] req_round_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [127:0]  rsp_key_o;
    logic [RW-1:0] rsp_round_o;
    logic          rsp_err_o;
    logic          busy_o;

    aes_round_key_engine #(.MAX_ROUND(MAX_ROUND), .RW(RW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_key_i   (req_key_i),
        .req_round_i (req_round_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_key_o   (rsp_key_o),
        .rsp_round_o (rsp_round_o),
        .rsp_err_o   (rsp_err_o),
        .busy_o      (busy_o)
    );

    // Key schedule of 000102..0f. Round 1 last word: w7 = w6 ^ w3 =
    // daa678f1 ^ 0c0d0e0f = d6ab76fe.
    logic [127:0] c_k1 [0:10] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };
    // Key schedule of 2b7e1516..4f3c (rounds 0, 4, 7, 10 used).
    logic [127:0] c_k2_r0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    logic [127:0] c_k2_r4  = 128'hef44a541a8525b7fb671253bdb0bad00;
    logic [127:0] c_k2_r7  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    logic [127:0] c_k2_r10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    typedef struct {
        logic [127:0]  key;
        logic [RW-1:0] round;
        logic          err;
        int            acc;
        int            lat;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    bit     seen   = 1'b0;

    // Reference cache state (used only when the cache is built in).
    bit           m_valid = 1'b0;
    logic [127:0] m_tag   = '0;
    int           m_hw    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: actual=timeout required=event", name);
    endtask

    // Monitor: compare each new response against the head of the scoreboard.
    initial begin
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (rsp_valid_o) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (sb.size() == 0) begin
                        timeout_fail("unexpected_rsp");
                    end else begin
                        e   = sb.pop_front();
                        lat = cyc - e.acc + 1;
                        check("rsp_latency", 128'(lat), 128'(e.lat));
                        check("rsp_key", rsp_key_o, e.key);
                        check("rsp_round", 128'(rsp_round_o), 128'(e.round));
                        check("rsp_err", 128'(rsp_err_o), 128'(e.err));
                    end
                end
                if (rsp_ready_i) seen = 1'b0;
            end
        end
    end

    // Issue one request, wait for acceptance and push its expectation.
    task automatic send(input logic [127:0] key, input int r, input logic [127:0] exp_key);
        int   n;
        exp_t e;
        @(posedge clk);
        #1;
        req_valid_i = 1'b1;
        req_key_i   = key;
        req_round_i = RW'(r);
        n = 0;
        @(negedge clk);
        while (!req_ready_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_o) begin
            timeout_fail("req_accept");
            req_valid_i = 1'b0;
            return;
        end
        e.acc   = cyc + 1;
        e.round = RW'(r);
        e.err   = (r > MAX_ROUND);
        e.key   = (r > MAX_ROUND) ? 128'h0 : exp_key;
        if (r > MAX_ROUND) begin
            e.lat = 1;
        end else if (CACHE_EN && m_valid && m_tag == key) begin
            if (r <= m_hw) begin
                e.lat = 1;
            end else begin
                e.lat = r - m_hw + 1;
                m_hw  = r;
            end
        end else begin
            e.lat = r + 1;
            if (CACHE_EN) begin
                m_valid = 1'b1;
                m_tag   = key;
                m_hw    = r;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        req_key_i   = ~key;
        req_round_i = ~RW'(r);
    endtask

    // Wait until every expected response has been seen and handshaken.
    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || seen) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || seen) timeout_fail("drain");
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        req_valid_i = 1'b0;
        req_key_i   = '0;
        req_round_i = '0;
        rsp_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp_valid", 128'(rsp_valid_o), 128'(0));
        check("reset_rsp_key", rsp_key_o, 128'h0);
        check("reset_rsp_round", 128'(rsp_round_o), 128'(0));
        check("reset_rsp_err", 128'(rsp_err_o), 128'(0));
        check("reset_busy", 128'(busy_o), 128'(0));
        check("reset_req_ready", 128'(req_ready_o), 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("req_ready_after_reset", 128'(req_ready_o), 128'(1));

        // Full, zero and single-round expansions, then an illegal round.
        send(c_k1[0], 10, c_k1[10]);
        send(c_k1[0], 0,  c_k1[0]);
        send(c_k1[0], 1,  c_k1[1]);
        send(c_k1[0], 11, 128'h0);
        send(c_k1[0], 10, c_k1[10]);
        drain();

        // Reverse-order requests as issued by a decryptor.
        for (int r = 9; r >= 0; r--) send(c_k1[0], r, c_k1[r]);
        drain();

        // New key: round 4, then round 7 continuing from the stored round 4.
        send(c_k2_r0, 4, c_k2_r4);
        send(c_k2_r0, 7, c_k2_r7);
        drain();

        // Backpressure: response held for 5 cycles must not move.
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b0;
        send(c_k2_r0, 10, c_k2_r10);
        n = 0;
        while (!rsp_valid_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid_o) timeout_fail("bp_rsp_valid");
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 128'(rsp_valid_o), 128'(1));
            check("bp_rsp_key", rsp_key_o, c_k2_r10);
            check("bp_req_ready", 128'(req_ready_o), 128'(0));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b1;
        drain();

        // Reset in the middle of a 10-round expansion drops the transaction.
        send(c_k1[0], 10, c_k1[10]);
        repeat (3) @(negedge clk);
        check("mid_busy", 128'(busy_o), 128'(1));
        check("mid_rsp_valid", 128'(rsp_valid_o), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 128'(rsp_valid_o), 128'(0));
        check("rst_busy", 128'(busy_o), 128'(0));
        check("rst_req_ready", 128'(req_ready_o), 128'(0));
        sb.delete();
        m_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(c_k2_r0, 10, c_k2_r10);
        drain();
        repeat (5) @(negedge clk);
        check("no_spurious_rsp", 128'(rsp_valid_o), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
